// File: rtl/wb_arb_pkg.sv
// Shared widths for the writeback arbiter. The `define block below plays the role of def.h:
// DATA_W, REG_W, REG, LWB_DEPTH and LWB_PTR_W can be overridden on the command line.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REG_W
`define REG_W 5
`endif
`ifndef REG
`define REG 32
`endif
`ifndef LWB_DEPTH
`define LWB_DEPTH 4
`endif
`ifndef LWB_PTR_W
`define LWB_PTR_W 2
`endif

package wb_arb_pkg;
  localparam int DATA_W    = `DATA_W;
  localparam int REG_W     = `REG_W;
  localparam int NREG      = `REG;
  localparam int LWB_DEPTH = `LWB_DEPTH;
  localparam int LWB_PTR_W = `LWB_PTR_W;
  localparam int CNT_W     = LWB_PTR_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] reg_mask(input logic [REG_W-1:0] r);
    return NREG'(1) << r;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Long-result buffer: circular FIFO exposing the two oldest entries so up to two
// entries can retire per cycle.
module wb_fifo import wb_arb_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic [1:0]       pop,
  output wb_entry_t        head0,
  output wb_entry_t        head1,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  wb_entry_t             mem [LWB_DEPTH];
  logic [LWB_PTR_W-1:0]  rd_ptr;
  logic [LWB_PTR_W-1:0]  wr_ptr;
  logic [LWB_PTR_W-1:0]  rd_nxt;

  assign rd_nxt = rd_ptr + 1'b1;
  assign head0  = mem[rd_ptr];
  assign head1  = mem[rd_nxt];
  assign full   = (count == CNT_W'(LWB_DEPTH));
  assign empty  = (count == '0);

  // Pointers wrap naturally because their width is log2 of the depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr + LWB_PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: merges pipe A/B ALU results and buffered long results onto two
// registered register-file write ports. Define WB_BYPASS_EN to let a long result skip the buffer.
module wb_arb import wb_arb_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_dst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_dst,
  input  logic [DATA_W-1:0] b_data,
  input  logic              l_valid,
  input  logic [REG_W-1:0]  l_dst,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_ready,
  input  logic              set_busy,
  input  logic [REG_W-1:0]  set_dst,
  output logic [NREG-1:0]   busy,
  output logic              we3_a,
  output logic [REG_W-1:0]  a3_a,
  output logic [DATA_W-1:0] wd3_a,
  output logic              we3_b,
  output logic [REG_W-1:0]  a3_b,
  output logic [DATA_W-1:0] wd3_b
);
  // l_valid/l_ready: a long result transfers at a posedge where both are high;
  // l_ready depends only on registered state, never on l_valid.
  wb_entry_t        head0, head1, l_ent, b_ent;
  logic [CNT_W-1:0] count;
  logic             full, empty, live_q, l_acc, push;
  logic [1:0]       pop;
  logic             n_we_a, n_we_b;
  logic [REG_W-1:0] n_a3_a, n_a3_b;
  logic [DATA_W-1:0] n_wd_a, n_wd_b;
  logic [NREG-1:0]  clr, set;

  assign l_ready = live_q && !full;
  assign l_acc   = l_valid && l_ready;
  assign l_ent   = '{dst: l_dst, data: l_data};
  assign set     = (set_busy && set_dst != '0) ? reg_mask(set_dst) : '0;

  wb_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (l_ent),
    .pop   (pop),
    .head0 (head0),
    .head1 (head1),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    n_we_a = 1'b0; n_a3_a = '0; n_wd_a = '0;
    n_we_b = 1'b0; n_a3_b = '0; n_wd_b = '0;
    push = 1'b0; pop = 2'd0; clr = '0;
    b_ent = head0;
    // ALU results own their port; the older A loses a same-register collision.
    if (a_valid) begin
      n_we_a = (a_dst != '0) && !(b_valid && b_dst == a_dst);
      n_a3_a = a_dst;
      n_wd_a = a_data;
    end else if (!empty) begin
      n_we_a = (head0.dst != '0);
      n_a3_a = head0.dst;
      n_wd_a = head0.data;
      pop    = 2'd1;
      clr    = clr | reg_mask(head0.dst);
    end
    if (b_valid) begin
      n_we_b = (b_dst != '0);
      n_a3_b = b_dst;
      n_wd_b = b_data;
    end else if (count > CNT_W'(pop)) begin
      b_ent  = pop[0] ? head1 : head0;
      n_we_b = (b_ent.dst != '0);
      n_a3_b = b_ent.dst;
      n_wd_b = b_ent.data;
      pop    = pop + 2'd1;
      clr    = clr | reg_mask(b_ent.dst);
    end
`ifdef WB_BYPASS_EN
    // Only an empty buffer may be bypassed, so nothing ever overtakes older entries.
    if (l_acc && empty && !a_valid) begin
      n_we_a = (l_dst != '0);
      n_a3_a = l_dst;
      n_wd_a = l_data;
      clr    = clr | reg_mask(l_dst);
    end else if (l_acc && empty && !b_valid) begin
      n_we_b = (l_dst != '0);
      n_a3_b = l_dst;
      n_wd_b = l_data;
      clr    = clr | reg_mask(l_dst);
    end else begin
      push = l_acc;
    end
`else
    push = l_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3_a  <= 1'b0; a3_a <= '0; wd3_a <= '0;
      we3_b  <= 1'b0; a3_b <= '0; wd3_b <= '0;
      busy   <= '0;
      live_q <= 1'b0;
    end else begin
      we3_a  <= n_we_a; a3_a <= n_a3_a; wd3_a <= n_wd_a;
      we3_b  <= n_we_b; a3_b <= n_a3_b; wd3_b <= n_wd_b;
      busy   <= (busy & ~clr) | set;
      live_q <= 1'b1;
    end
  end

  // An ALU result aimed at a register still awaiting a long result is an upstream bug.
  a_dst_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (a_valid && a_dst != '0) |-> !busy[a_dst]);
  b_dst_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (b_valid && b_dst != '0) |-> !busy[b_dst]);
endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios followed by random traffic, every cycle compared
// against a queue-based reference of pending long results and a busy bitmap.
module tb_wb_arb;
  import wb_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, b_valid, l_valid, set_busy;
  logic [REG_W-1:0]  a_dst, b_dst, l_dst, set_dst;
  logic [DATA_W-1:0] a_data, b_data, l_data;
  logic              l_ready, we3_a, we3_b;
  logic [NREG-1:0]   busy;
  logic [REG_W-1:0]  a3_a, a3_b;
  logic [DATA_W-1:0] wd3_a, wd3_b;

  int total = 0;
  int bad = 0;
  logic [REG_W+DATA_W-1:0] exp_q[$];
  logic [NREG-1:0]         m_busy;
  logic                    m_live;

  always #5 clk = ~clk;

  wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_dst(a_dst), .a_data(a_data),
    .b_valid(b_valid), .b_dst(b_dst), .b_data(b_data),
    .l_valid(l_valid), .l_dst(l_dst), .l_data(l_data), .l_ready(l_ready),
    .set_busy(set_busy), .set_dst(set_dst), .busy(busy),
    .we3_a(we3_a), .a3_a(a3_a), .wd3_a(wd3_a),
    .we3_b(we3_b), .a3_b(a3_b), .wd3_b(wd3_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; a_dst = '0; a_data = '0;
    b_valid = 1'b0; b_dst = '0; b_data = '0;
    l_valid = 1'b0; l_dst = '0; l_data = '0;
    set_busy = 1'b0; set_dst = '0;
  endtask

  // Predict one clock edge from the current inputs, advance, then compare.
  task automatic cycle();
    logic              ewa, ewb, acc, was_empty;
    logic [REG_W-1:0]  eaa, eab, d;
    logic [DATA_W-1:0] eda, edb, v;
    ewa = 1'b0; ewb = 1'b0; eaa = '0; eab = '0; eda = '0; edb = '0;
    if (!rst_n) begin
      exp_q.delete();
      m_busy = '0;
      m_live = 1'b0;
    end else begin
      acc = l_valid && m_live && (exp_q.size() < LWB_DEPTH);
      was_empty = (exp_q.size() == 0);
      if (a_valid) begin
        ewa = (a_dst != '0) && !(b_valid && b_dst == a_dst); eaa = a_dst; eda = a_data;
      end else if (exp_q.size() != 0) begin
        {d, v} = exp_q.pop_front();
        ewa = (d != '0); eaa = d; eda = v; m_busy[d] = 1'b0;
      end
      if (b_valid) begin
        ewb = (b_dst != '0); eab = b_dst; edb = b_data;
      end else if (exp_q.size() != 0) begin
        {d, v} = exp_q.pop_front();
        ewb = (d != '0); eab = d; edb = v; m_busy[d] = 1'b0;
      end
`ifdef WB_BYPASS_EN
      if (acc && was_empty && !a_valid) begin
        ewa = (l_dst != '0); eaa = l_dst; eda = l_data; m_busy[l_dst] = 1'b0; acc = 1'b0;
      end else if (acc && was_empty && !b_valid) begin
        ewb = (l_dst != '0); eab = l_dst; edb = l_data; m_busy[l_dst] = 1'b0; acc = 1'b0;
      end
`endif
      if (acc) exp_q.push_back({l_dst, l_data});
      if (set_busy && set_dst != '0) m_busy[set_dst] = 1'b1;
      m_live = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("l_ready", 64'(l_ready), 64'(m_live && (exp_q.size() < LWB_DEPTH)));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("we3_a", 64'(we3_a), 64'(ewa));
    chk("we3_b", 64'(we3_b), 64'(ewb));
    if (ewa || !rst_n) begin
      chk("a3_a", 64'(a3_a), 64'(eaa));
      chk("wd3_a", 64'(wd3_a), 64'(eda));
    end
    if (ewb || !rst_n) begin
      chk("a3_b", 64'(a3_b), 64'(eab));
      chk("wd3_b", 64'(wd3_b), 64'(edb));
    end
  endtask

  initial begin
    m_busy = '0;
    m_live = 1'b0;
    idle();

    // Reset state and release
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_l_ready", 64'(l_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("release_l_ready", 64'(l_ready), 64'd1);

    // Two independent ALU results
    a_valid = 1'b1; a_dst = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_dst = 5'd4; b_data = 32'h22;
    cycle();
    chk("dual_we_a", 64'(we3_a), 64'd1);
    chk("dual_a3_a", 64'(a3_a), 64'd3);
    chk("dual_wd_a", 64'(wd3_a), 64'h11);
    chk("dual_we_b", 64'(we3_b), 64'd1);
    chk("dual_a3_b", 64'(a3_b), 64'd4);
    chk("dual_wd_b", 64'(wd3_b), 64'h22);

    // Same destination: younger B wins
    a_dst = 5'd5; a_data = 32'hAA;
    b_dst = 5'd5; b_data = 32'hBB;
    cycle();
    chk("coll_we_a", 64'(we3_a), 64'd0);
    chk("coll_we_b", 64'(we3_b), 64'd1);
    chk("coll_a3_b", 64'(a3_b), 64'd5);
    chk("coll_wd_b", 64'(wd3_b), 64'hBB);

    // Busy set, then long result written back
    idle();
    set_busy = 1'b1; set_dst = 5'd7;
    cycle();
    chk("busy7_set", 64'(busy[7]), 64'd1);
    idle();
    cycle();
    cycle();
    l_valid = 1'b1; l_dst = 5'd7; l_data = 32'h77;
    cycle();
    l_valid = 1'b0;
`ifndef WB_BYPASS_EN
    chk("l7_not_yet", 64'(we3_a), 64'd0);
    chk("busy7_still", 64'(busy[7]), 64'd1);
    cycle();
`endif
    chk("l7_we_a", 64'(we3_a), 64'd1);
    chk("l7_a3_a", 64'(a3_a), 64'd7);
    chk("l7_wd_a", 64'(wd3_a), 64'h77);
    chk("busy7_clr", 64'(busy[7]), 64'd0);
    idle();
    cycle();

    // Buffer fills while both ports are held by ALU traffic
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_dst = 5'd1; a_data = $urandom();
      b_valid = 1'b1; b_dst = 5'd2; b_data = $urandom();
      l_valid = 1'b1; l_dst = REG_W'(16 + k); l_data = DATA_W'(32'h100 + k);
      if (k == 4) chk("full_l_ready", 64'(l_ready), 64'd0);
      cycle();
    end
    idle();
    cycle();
    chk("drain0_a3_a", 64'(a3_a), 64'd16);
    chk("drain0_wd_a", 64'(wd3_a), 64'h100);
    chk("drain1_a3_b", 64'(a3_b), 64'd17);
    chk("drain1_wd_b", 64'(wd3_b), 64'h101);
    cycle();
    chk("drain2_a3_a", 64'(a3_a), 64'd18);
    chk("drain3_a3_b", 64'(a3_b), 64'd19);
    cycle();
    chk("drained_we_a", 64'(we3_a), 64'd0);

    // Long result to r0 is swallowed
    l_valid = 1'b1; l_dst = '0; l_data = 32'h55;
    cycle();
    idle();
    chk("r0_we_a", 64'(we3_a), 64'd0);
    cycle();
    chk("r0_we_a_later", 64'(we3_a), 64'd0);
    chk("r0_busy", 64'(busy), 64'd0);

    // Reset in the middle of buffered work
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_dst = 5'd1; a_data = $urandom();
      b_valid = 1'b1; b_dst = 5'd3; b_data = $urandom();
      l_valid = 1'b1; l_dst = REG_W'(20 + k); l_data = $urandom();
      cycle();
    end
    l_valid = 1'b0;
    set_busy = 1'b1; set_dst = 5'd2;
    cycle();
    set_dst = 5'd9;
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_l_ready", 64'(l_ready), 64'd0);
    chk("midrst_we_a", 64'(we3_a), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("midrst_release_ready", 64'(l_ready), 64'd1);
    cycle();
    chk("midrst_no_write_a", 64'(we3_a), 64'd0);
    chk("midrst_no_write_b", 64'(we3_b), 64'd0);

    // Random traffic: ALU results on r0..r15, long results and busy on r16..r31
    for (int i = 0; i < 500; i++) begin
      a_valid  = ($urandom_range(0, 9) < 6);
      a_dst    = REG_W'($urandom_range(0, 15));
      a_data   = $urandom();
      b_valid  = ($urandom_range(0, 9) < 6);
      b_dst    = ($urandom_range(0, 3) == 0) ? a_dst : REG_W'($urandom_range(0, 15));
      b_data   = $urandom();
      l_valid  = ($urandom_range(0, 1) == 1);
      l_dst    = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom_range(16, 31));
      l_data   = $urandom();
      set_busy = ($urandom_range(0, 3) == 0);
      set_dst  = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom_range(16, 31));
      rst_n    = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
